// File: rtl/robot_pkg.sv
// Shared robot-wide definitions: scan state encoding and 50 MHz timing constants
// used by the ranging, encoder and UART blocks.
package robot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } scan_state_t;

    localparam int SCAN_SETTLE_CYCLES  = 50;
    localparam int SCAN_TRIG_CYCLES    = 500;
    localparam int SCAN_CYCLES_PER_CM  = 2900;
    localparam int SCAN_TIMEOUT_CYCLES = 1_500_000;
    localparam int SCAN_GAP_CYCLES     = 500_000;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser for asynchronous inputs
// (echo, encoder channels, UART receive line).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/ultrasonic_scanner.sv
// Ultrasonic ranging front-end: steps the sensor mux, fires triggers, times the
// echo and reports one distance (or timeout) per channel.
module ultrasonic_scanner
    import robot_pkg::*;
#(
    parameter int NUM_SENSORS    = 4,
    parameter int SETTLE_CYCLES  = SCAN_SETTLE_CYCLES,
    parameter int TRIG_CYCLES    = SCAN_TRIG_CYCLES,
    parameter int CYCLES_PER_CM  = SCAN_CYCLES_PER_CM,
    parameter int TIMEOUT_CYCLES = SCAN_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = SCAN_GAP_CYCLES,
    parameter int DIST_W         = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              echo_rx,
    output logic              trig_tx,
    output logic [3:0]        mux_sensor_select,
    output logic              dist_valid,
    output logic [3:0]        dist_sensor,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_timeout
);

    localparam int PHASE_MAX = max4(SETTLE_CYCLES, TRIG_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES);
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int PRESC_W   = $clog2(CYCLES_PER_CM + 1);

    localparam logic [PHASE_W-1:0] SETTLE_LAST  = PHASE_W'(SETTLE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] TRIG_LAST    = PHASE_W'(TRIG_CYCLES - 1);
    localparam logic [PHASE_W-1:0] TIMEOUT_LAST = PHASE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] GAP_LAST     = PHASE_W'(GAP_CYCLES - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST   = PRESC_W'(CYCLES_PER_CM - 1);
    localparam logic [DIST_W-1:0]  DIST_MAX     = '1;
    localparam logic [3:0]         IDX_LAST     = 4'(NUM_SENSORS - 1);

    scan_state_t        state_reg, state_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [DIST_W-1:0]  cm_reg, cm_next;
    logic [3:0]         idx_reg, idx_next;
    logic               trig_reg;
    logic               valid_reg, valid_next;
    logic [3:0]         sensor_reg, sensor_next;
    logic [DIST_W-1:0]  dist_reg, dist_next;
    logic               tmo_reg, tmo_next;

    logic echo_sync;
    logic echo_prev_reg;
    logic echo_rise;
    logic echo_fall;

    sync_2ff #(.RESET_VAL(1'b0)) u_echo_sync (
        .clk   (clk),
        .reset (reset),
        .d     (echo_rx),
        .q     (echo_sync)
    );

    // Edges only, so a level that is already high when listening starts never counts.
    assign echo_rise = echo_sync & ~echo_prev_reg;
    assign echo_fall = ~echo_sync & echo_prev_reg;

    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg + PHASE_W'(1);
        presc_next  = presc_reg;
        cm_next     = cm_reg;
        idx_next    = idx_reg;
        valid_next  = 1'b0;
        sensor_next = sensor_reg;
        dist_next   = dist_reg;
        tmo_next    = tmo_reg;

        case (state_reg)
            IDLE: begin
                phase_next = '0;
                if (enable) state_next = SETTLE;
            end
            SETTLE: begin
                if (!enable) begin
                    state_next = IDLE;
                    phase_next = '0;
                end else if (phase_reg == SETTLE_LAST) begin
                    state_next = TRIG;
                    phase_next = '0;
                end
            end
            TRIG: begin
                if (!enable) begin
                    state_next = IDLE;
                    phase_next = '0;
                end else if (phase_reg == TRIG_LAST) begin
                    state_next = WAIT_RISE;
                    phase_next = '0;
                end
            end
            WAIT_RISE: begin
                if (!enable) begin
                    state_next = IDLE;
                    phase_next = '0;
                end else if (echo_rise) begin
                    state_next = MEASURE;
                    phase_next = '0;
                    presc_next = '0;
                    cm_next    = '0;
                end else if (phase_reg == TIMEOUT_LAST) begin
                    state_next  = GAP;
                    phase_next  = '0;
                    valid_next  = 1'b1;
                    sensor_next = idx_reg;
                    dist_next   = DIST_MAX;
                    tmo_next    = 1'b1;
                end
            end
            MEASURE: begin
                // The falling edge is tested before the width limit so a coincident edge wins.
                if (!enable) begin
                    state_next = IDLE;
                    phase_next = '0;
                end else if (echo_fall) begin
                    state_next  = GAP;
                    phase_next  = '0;
                    valid_next  = 1'b1;
                    sensor_next = idx_reg;
                    dist_next   = cm_reg;
                    tmo_next    = 1'b0;
                end else if (phase_reg == TIMEOUT_LAST) begin
                    state_next  = GAP;
                    phase_next  = '0;
                    valid_next  = 1'b1;
                    sensor_next = idx_reg;
                    dist_next   = DIST_MAX;
                    tmo_next    = 1'b1;
                end else if (presc_reg == PRESC_LAST) begin
                    presc_next = '0;
                    if (cm_reg != DIST_MAX) cm_next = cm_reg + DIST_W'(1);
                end else begin
                    presc_next = presc_reg + PRESC_W'(1);
                end
            end
            GAP: begin
                if (phase_reg == GAP_LAST) begin
                    phase_next = '0;
                    idx_next   = (idx_reg == IDX_LAST) ? 4'd0 : idx_reg + 4'd1;
                    state_next = enable ? SETTLE : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            presc_reg     <= '0;
            cm_reg        <= '0;
            idx_reg       <= '0;
            trig_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            sensor_reg    <= '0;
            dist_reg      <= '0;
            tmo_reg       <= 1'b0;
            echo_prev_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            presc_reg     <= presc_next;
            cm_reg        <= cm_next;
            idx_reg       <= idx_next;
            trig_reg      <= (state_next == TRIG);
            valid_reg     <= valid_next;
            sensor_reg    <= sensor_next;
            dist_reg      <= dist_next;
            tmo_reg       <= tmo_next;
            echo_prev_reg <= echo_sync;
        end
    end

    assign trig_tx           = trig_reg;
    assign mux_sensor_select = idx_reg;
    assign dist_valid        = valid_reg;
    assign dist_sensor       = sensor_reg;
    assign dist_cm           = dist_reg;
    assign dist_timeout      = tmo_reg;

endmodule
